ext_mem_loader: RTL and testbench

Boot loader that sits directly upstream of the `cpu` external memory ports. It accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit words, writes the data-memory image through the `_ext_2` port and then the instruction-memory image through the `_ext` port, and finally raises `enable` to start the core. This is the hardware equivalent of the bench-side load sequence, so the design boots without simulator tasks.

---
 rtl/ext_mem_loader.sv | 180 ++++++++++++++++++
 tb/tb_ext_mem_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_loader.sv
// Boot loader: packs an MSB-first byte stream into words, writes the data image, then the
// instruction image, then enables the core. Define LOADER_CHECKSUM_EN to add a trailing checksum.
module ext_mem_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic [31:0] addr_ext_o,
  output logic [31:0] wdata_ext_o,
  output logic        wen_ext_o,
  output logic        ren_ext_o,
  output logic [31:0] addr_ext_2_o,
  output logic [31:0] wdata_ext_2_o,
  output logic        wen_ext_2_o,
  output logic        ren_ext_2_o,
  output logic        enable_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned MaxWords = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
  localparam int unsigned IdxW     = $clog2(MaxWords) + 1;
  localparam logic [IdxW-1:0] DLast = IdxW'(DMEM_WORDS - 1);
  localparam logic [IdxW-1:0] ILast = IdxW'(IMEM_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadD,
    StLoadI,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
    StError,
`endif
    StRun
  } state_e;

  state_e          state_q;
  logic [1:0]      byte_cnt_q;
  logic [23:0]     shift_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     addr_ext_q, wdata_ext_q, addr_ext_2_q, wdata_ext_2_q;
  logic            wen_ext_q, wen_ext_2_q, enable_q;
  logic            busy, accept, word_done;
  logic [31:0]     word_d, word_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     csum_q;
  logic            err_q;
`endif

  always_comb begin
    busy = (state_q == StLoadD) || (state_q == StLoadI);
`ifdef LOADER_CHECKSUM_EN
    busy = busy || (state_q == StCheck);
`endif
  end

  assign accept    = in_valid_i && busy;
  assign word_done = accept && (byte_cnt_q == 2'd3);
  assign word_d    = {shift_q, in_data_i};
  assign word_addr = 32'(idx_q) << 2;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q       <= StIdle;
      byte_cnt_q    <= 2'd0;
      shift_q       <= 24'd0;
      idx_q         <= '0;
      addr_ext_q    <= 32'd0;
      wdata_ext_q   <= 32'd0;
      wen_ext_q     <= 1'b0;
      addr_ext_2_q  <= 32'd0;
      wdata_ext_2_q <= 32'd0;
      wen_ext_2_q   <= 1'b0;
      enable_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= 32'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      // Write strobes and their address/data are single-cycle; idle value is 0.
      wen_ext_q     <= 1'b0;
      addr_ext_q    <= 32'd0;
      wdata_ext_q   <= 32'd0;
      wen_ext_2_q   <= 1'b0;
      addr_ext_2_q  <= 32'd0;
      wdata_ext_2_q <= 32'd0;
      if (accept) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        shift_q    <= {shift_q[15:0], in_data_i};
      end
      if (start_i && !busy) begin
        state_q    <= StLoadD;
        byte_cnt_q <= 2'd0;
        idx_q      <= '0;
        enable_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_q     <= 32'd0;
        err_q      <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StLoadD: begin
            if (word_done) begin
              wen_ext_2_q   <= 1'b1;
              addr_ext_2_q  <= word_addr;
              wdata_ext_2_q <= word_d;
`ifdef LOADER_CHECKSUM_EN
              csum_q        <= csum_q + word_d;
`endif
              if (idx_q == DLast) begin
                state_q <= StLoadI;
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          StLoadI: begin
            if (word_done) begin
              wen_ext_q   <= 1'b1;
              addr_ext_q  <= word_addr;
              wdata_ext_q <= word_d;
`ifdef LOADER_CHECKSUM_EN
              csum_q      <= csum_q + word_d;
`endif
              if (idx_q == ILast) begin
`ifdef LOADER_CHECKSUM_EN
                state_q <= StCheck;
`else
                state_q <= StRun;
`endif
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          StCheck: begin
            if (word_done) begin
              if (word_d == csum_q) begin
                state_q <= StRun;
              end else begin
                state_q <= StError;
                err_q   <= 1'b1;
              end
            end
          end
`endif
          // Enable is raised one cycle after entering RUN.
          StRun:   enable_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign in_ready_o    = busy;
  assign busy_o        = busy;
  assign addr_ext_o    = addr_ext_q;
  assign wdata_ext_o   = wdata_ext_q;
  assign wen_ext_o     = wen_ext_q;
  assign ren_ext_o     = 1'b0;
  assign addr_ext_2_o  = addr_ext_2_q;
  assign wdata_ext_2_o = wdata_ext_2_q;
  assign wen_ext_2_o   = wen_ext_2_q;
  assign ren_ext_2_o   = 1'b0;
  assign enable_o      = enable_q;
`ifdef LOADER_CHECKSUM_EN
  assign err_o         = err_q;
`else
  assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_ext_mem_loader.sv
// Randomized bench for ext_mem_loader with a small image and a word-level reference model.
module tb_ext_mem_loader;

  localparam int unsigned D = 4;
  localparam int unsigned I = 2;

  logic        clk = 1'b0;
  logic        arst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, busy, err;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;

  ext_mem_loader #(.IMEM_WORDS(I), .DMEM_WORDS(D)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .start_i      (start),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .addr_ext_o   (addr_ext),
    .wdata_ext_o  (wdata_ext),
    .wen_ext_o    (wen_ext),
    .ren_ext_o    (ren_ext),
    .addr_ext_2_o (addr_ext_2),
    .wdata_ext_2_o(wdata_ext_2),
    .wen_ext_2_o  (wen_ext_2),
    .ren_ext_2_o  (ren_ext_2),
    .enable_o     (enable),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Write log captured from the ports; only this monitor writes these.
  logic [31:0] d_addr[$], d_data[$], i_addr[$], i_data[$];
  int          d_cyc[$], i_cyc[$];
  int          idle_bad = 0;
  int          en_rise  = -1;
  logic        en_prev  = 1'b0;

  always @(negedge clk) begin
    if (wen_ext_2) begin
      d_addr.push_back(addr_ext_2); d_data.push_back(wdata_ext_2); d_cyc.push_back(cyc);
    end else if (addr_ext_2 != 0 || wdata_ext_2 != 0) idle_bad++;
    if (wen_ext) begin
      i_addr.push_back(addr_ext); i_data.push_back(wdata_ext); i_cyc.push_back(cyc);
    end else if (addr_ext != 0 || wdata_ext != 0) idle_bad++;
    if (ren_ext || ren_ext_2) idle_bad++;
    if (enable && !en_prev) en_rise = cyc;
    en_prev = enable;
  end

  logic [31:0] stream[$];

  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 200 && !acc; t++) begin
      acc = in_ready;
      @(negedge clk);
    end
    if (!acc) check_eq("byte_timeout", 0, 1);
  endtask

  task automatic run_load(input int gap_pct, input int start_at, input bit bad_sum);
    logic [31:0] sum = 0;
    logic [31:0] w;
    logic [7:0]  bytes[$];
    int d0 = d_addr.size();
    int i0 = i_addr.size();
    int bad0 = idle_bad;
    foreach (stream[k]) begin
      w = stream[k];
      sum += w;
      for (int s = 3; s >= 0; s--) bytes.push_back(w[8*s +: 8]);
    end
`ifdef LOADER_CHECKSUM_EN
    w = bad_sum ? sum - 1 : sum;
    for (int s = 3; s >= 0; s--) bytes.push_back(w[8*s +: 8]);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_en_low", {31'd0, enable}, 0);
    check_eq("start_busy", {31'd0, busy}, 1);
`ifdef LOADER_CHECKSUM_EN
    check_eq("start_err_clr", {31'd0, err}, 0);
`endif
    foreach (bytes[k]) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      start = (k == start_at);
      send_byte(bytes[k]);
      start = 1'b0;
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    check_eq("d_count", d_addr.size() - d0, D);
    check_eq("i_count", i_addr.size() - i0, I);
    for (int k = 0; k < D && d0 + k < d_addr.size(); k++) begin
      check_eq("d_addr", d_addr[d0+k], 32'(k * 4));
      check_eq("d_data", d_data[d0+k], stream[k]);
      if (gap_pct == 0 && k > 0) check_eq("d_spacing", d_cyc[d0+k] - d_cyc[d0+k-1], 4);
    end
    for (int k = 0; k < I && i0 + k < i_addr.size(); k++) begin
      check_eq("i_addr", i_addr[i0+k], 32'(k * 4));
      check_eq("i_data", i_data[i0+k], stream[D+k]);
    end
    if (gap_pct == 0 && d_addr.size() - d0 == D && i_addr.size() - i0 == I)
      check_eq("d_to_i_gap", i_cyc[i0] - d_cyc[d0+D-1], 4);
    check_eq("idle_zero", idle_bad - bad0, 0);
`ifdef LOADER_CHECKSUM_EN
    check_eq("chk_err", {31'd0, err}, {31'd0, bad_sum});
    check_eq("chk_enable", {31'd0, enable}, {31'd0, !bad_sum});
`else
    check_eq("enable", {31'd0, enable}, 1);
    if (i_addr.size() - i0 == I) check_eq("enable_lat", en_rise, i_cyc[i0+I-1] + 1);
`endif
  endtask

  task automatic rand_stream();
    stream.delete();
    for (int k = 0; k < D + I; k++) stream.push_back($urandom);
  endtask

  initial begin
    arst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_flags", {24'd0, wen_ext, wen_ext_2, ren_ext, ren_ext_2, enable, busy,
                           in_ready, err}, 0);
    check_eq("rst_bus", addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2, 0);
    arst = 1'b0;
    @(negedge clk);

    // Reset after two bytes of data word 5 (past the small image into LOAD_I).
    rand_stream();
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 22; k++) send_byte(8'($urandom));
    check_eq("pre_rst_busy", {31'd0, busy}, 1);
    in_valid = 1'b0;
    arst = 1'b1;
    @(negedge clk);
    check_eq("midrst_flags", {24'd0, wen_ext, wen_ext_2, ren_ext, ren_ext_2, enable, busy,
                              in_ready, err}, 0);
    check_eq("midrst_bus", addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2, 0);
    start = 1'b1;
    @(negedge clk);
    check_eq("rst_beats_start", {31'd0, busy}, 0);
    arst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("idle_after_rst", {31'd0, busy}, 0);

    stream = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004,
               32'h2010_0007, 32'hF800_0000};
    run_load(0, -1, 1'b0);

    // Byte order, plus a start pulse accepted alongside a LOAD_I byte (must be ignored).
    rand_stream();
    stream[0] = 32'h1234_5678;
    run_load(0, 4 * D + 2, 1'b0);

    for (int r = 0; r < 3; r++) begin
      rand_stream();
      run_load(40, -1, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    stream = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004,
               32'h2010_0007, 32'hF800_0000};
    run_load(0, -1, 1'b1);
    rand_stream();
    run_load(20, -1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
